z_result_collector: RTL and testbench

Responder end of the `z_*` result handshake driven by the matrix multiplier datapath. It accepts each 32-bit result word at its (z_i, z_j) position in an m×m register matrix, and returns the stored word on `current_element` so the multiplier can accumulate partial products across sub-blocks. On request, it drains the finished matrix in row-major order over a valid/ready stream to the output interface.

---
 rtl/z_result_collector_pkg.sv | 17 +
 rtl/z_cell_matrix.sv | 59 +++++
 rtl/z_result_collector.sv | 134 +++++++++++++
 tb/tb_z_result_collector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/z_result_collector_pkg.sv
// Shared types and constants for the z_* result collector and the multiplier datapath.
package z_result_collector_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t;

  // Index width for an n-entry dimension; never below 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/z_cell_matrix.sv
// m x m result register array: one synchronous write port, synchronous clear,
// combinational accumulate and drain read ports.
module z_cell_matrix
  import z_result_collector_pkg::*;
#(
  parameter int unsigned m     = 4,
  parameter int unsigned m_len = idx_width(m)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              we,
  input  logic [m_len-1:0]  wr_i,
  input  logic [m_len-1:0]  wr_j,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [m_len-1:0]  acc_i,
  input  logic [m_len-1:0]  acc_j,
  output logic [WORD_W-1:0] acc_data,
  input  logic [m_len-1:0]  drn_i,
  input  logic [m_len-1:0]  drn_j,
  output logic [WORD_W-1:0] drn_data
);

  localparam int unsigned LIM_W = m_len + 1;
  localparam logic [LIM_W-1:0] M_LIM = LIM_W'(m);

  logic [WORD_W-1:0] cells [m][m];
  logic              acc_ok;
  logic              drn_ok;

  // Clear first so a coincident write still lands in its cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < m; j++) begin
          cells[i][j] <= '0;
        end
      end
    end else begin
      if (clear) begin
        for (int i = 0; i < m; i++) begin
          for (int j = 0; j < m; j++) begin
            cells[i][j] <= '0;
          end
        end
      end
      if (we) begin
        cells[wr_i][wr_j] <= wr_data;
      end
    end
  end

  // Out-of-range addresses (non power-of-two m) read as zero.
  assign acc_ok   = ({1'b0, acc_i} < M_LIM) && ({1'b0, acc_j} < M_LIM);
  assign drn_ok   = ({1'b0, drn_i} < M_LIM) && ({1'b0, drn_j} < M_LIM);
  assign acc_data = acc_ok ? cells[acc_i][acc_j] : '0;
  assign drn_data = drn_ok ? cells[drn_i][drn_j] : '0;

endmodule

// File: rtl/z_result_collector.sv
// Collects z_* result words into an m x m matrix, serves accumulate reads,
// and drains the matrix row-major over a valid/ready stream.
module z_result_collector
  import z_result_collector_pkg::*;
#(
  parameter int unsigned m     = 4,
  parameter int unsigned m_len = idx_width(m)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [WORD_W-1:0] z_out,
  input  logic [m_len-1:0]  z_i,
  input  logic [m_len-1:0]  z_j,
  input  logic              z_stb,
  output logic              z_ack,
  output logic [WORD_W-1:0] current_element,
  input  logic              rd_start,
  output logic [WORD_W-1:0] out_data,
  output logic [m_len-1:0]  out_i,
  output logic [m_len-1:0]  out_j,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned LIM_W = m_len + 1;
  localparam logic [LIM_W-1:0] M_LIM    = LIM_W'(m);
  localparam logic [m_len-1:0] LAST_IDX = m_len'(m - 1);

  state_t            state;
  logic              wr_fire;
  logic              in_range;
  logic              we;
  logic              clear_eff;
  logic [m_len-1:0]  nxt_i;
  logic [m_len-1:0]  nxt_j;
  logic [WORD_W-1:0] drn_data;

  // One write per handshake: the registered ack masks the still-high strobe.
  assign wr_fire   = z_stb && !z_ack;
  assign in_range  = ({1'b0, z_i} < M_LIM) && ({1'b0, z_j} < M_LIM);
  assign we        = (state == S_COLLECT) && wr_fire && in_range;
  assign clear_eff = (state == S_COLLECT) && clear;

  // Address of the beat to present after the next register update.
  always_comb begin
    nxt_i = out_i;
    nxt_j = out_j;
    if (state == S_COLLECT) begin
      nxt_i = '0;
      nxt_j = '0;
    end else if (out_j == LAST_IDX) begin
      nxt_i = out_i + m_len'(1);
      nxt_j = '0;
    end else begin
      nxt_j = out_j + m_len'(1);
    end
  end

  z_cell_matrix #(
    .m     (m),
    .m_len (m_len)
  ) u_cells (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_eff),
    .we       (we),
    .wr_i     (z_i),
    .wr_j     (z_j),
    .wr_data  (z_out),
    .acc_i    (z_i),
    .acc_j    (z_j),
    .acc_data (current_element),
    .drn_i    (nxt_i),
    .drn_j    (nxt_j),
    .drn_data (drn_data)
  );

  // Collect/drain FSM with ack, write counter and drain pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_COLLECT;
      z_ack     <= 1'b0;
      out_data  <= '0;
      out_i     <= '0;
      out_j     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      wr_count  <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          z_ack <= wr_fire;
          if (clear) begin
            wr_count <= (wr_fire && in_range) ? CNT_W'(1) : '0;
          end else if (wr_fire && in_range && (wr_count != '1)) begin
            wr_count <= wr_count + CNT_W'(1);
          end
          if (rd_start && !wr_fire) begin
            state     <= S_DRAIN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_i     <= '0;
            out_j     <= '0;
            out_data  <= drn_data;
            out_last  <= 1'(m == 1);
          end
        end
        S_DRAIN: begin
          z_ack <= 1'b0;
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= S_COLLECT;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_i    <= nxt_i;
              out_j    <= nxt_j;
              out_data <= drn_data;
              out_last <= (nxt_i == LAST_IDX) && (nxt_j == LAST_IDX);
            end
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_z_result_collector.sv
// Directed bench for z_result_collector: write handshake, drains, clear and reset.
module tb_z_result_collector;

  localparam int M  = 4;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [31:0]   z_out;
  logic [ML-1:0] z_i;
  logic [ML-1:0] z_j;
  logic          z_stb;
  logic          z_ack;
  logic [31:0]   current_element;
  logic          rd_start;
  logic [31:0]   out_data;
  logic [ML-1:0] out_i;
  logic [ML-1:0] out_j;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic [15:0]   wr_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [M][M];

  typedef struct {
    logic [ML-1:0] i;
    logic [ML-1:0] j;
    logic [31:0]   data;
    logic [15:0]   exp_cnt;
  } wr_vec_t;

  wr_vec_t vec [16];

  z_result_collector #(.m(M), .m_len(ML)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .z_out           (z_out),
    .z_i             (z_i),
    .z_j             (z_j),
    .z_stb           (z_stb),
    .z_ack           (z_ack),
    .current_element (current_element),
    .rd_start        (rd_start),
    .out_data        (out_data),
    .out_i           (out_i),
    .out_j           (out_j),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .busy            (busy),
    .wr_count        (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [ML-1:0] i, input logic [ML-1:0] j, input logic [31:0] d);
    z_i   = i;
    z_j   = j;
    z_out = d;
    z_stb = 1'b1;
    @(posedge clk); #1;
    chk("ack_pulse", 64'(z_ack), 64'(1));
    z_stb = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", 64'(z_ack), 64'(0));
  endtask

  task automatic start_drain();
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    chk("drain_start", 64'({out_valid, busy}), 64'(2'b11));
  endtask

  // Walks one drain, checking every cycle; non-ready cycles must hold the same beat.
  task automatic drain_beats(input bit toggle);
    int beats = 0;
    int cyc = 0;
    logic [38:0] exp;
    while (beats < M * M && cyc < 100) begin
      out_ready = toggle ? 1'(cyc % 2) : 1'b1;
      exp = {1'b1, 2'(beats / M), 2'(beats % M), mdl[beats / M][beats % M],
             1'(beats == M * M - 1), 1'b0};
      chk("drain_beat", 64'({out_valid, out_i, out_j, out_data, out_last, z_ack}), 64'(exp));
      if (!out_valid) break;
      if (out_ready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_count", 64'(beats), 64'(M * M));
    chk("drain_end", 64'({out_valid, busy}), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1; clear = 1'b0; z_stb = 1'b0; rd_start = 1'b0; out_ready = 1'b0;
    z_out = '0; z_i = '0; z_j = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        mdl[i][j] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 64'({z_ack, out_valid, out_last, busy, out_i, out_j, wr_count}), 64'(0));
    chk("reset_data", 64'(out_data), 64'(0));
    chk("reset_cur", 64'(current_element), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write and accumulate read-back.
    do_write(2'd1, 2'd2, 32'h3F80_0000);
    mdl[1][2] = 32'h3F80_0000;
    chk("cur_1_2", 64'(current_element), 64'h3F80_0000);
    chk("wr_count_1", 64'(wr_count), 64'(1));

    // Fill the matrix from the vector table.
    for (int k = 0; k < 16; k++)
      vec[k] = '{i: 2'(k / 4), j: 2'(k % 4), data: 32'h100 + 32'(k), exp_cnt: 16'(k + 2)};
    for (int k = 0; k < 16; k++) begin
      do_write(vec[k].i, vec[k].j, vec[k].data);
      mdl[vec[k].i][vec[k].j] = vec[k].data;
      chk("tbl_cur", 64'(current_element), 64'(vec[k].data));
      chk("tbl_cnt", 64'(wr_count), 64'(vec[k].exp_cnt));
    end

    // Full-rate drain, then a back-pressured drain.
    start_drain();
    drain_beats(1'b0);
    start_drain();
    drain_beats(1'b1);

    // Strobe raised during drain must stall until S_COLLECT.
    start_drain();
    z_i = 2'd2; z_j = 2'd1; z_out = 32'hCAFE_0001; z_stb = 1'b1;
    drain_beats(1'b0);
    chk("ack_stalled", 64'(z_ack), 64'(0));
    w = 0;
    while (!z_ack && w < 5) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ack_after_drain", 64'(w), 64'(1));
    z_stb = 1'b0;
    mdl[2][1] = 32'hCAFE_0001;
    @(posedge clk); #1;
    chk("ack_drop_post_drain", 64'(z_ack), 64'(0));
    chk("cur_2_1", 64'(current_element), 64'hCAFE_0001);
    chk("wr_count_18", 64'(wr_count), 64'(18));

    // Clear coinciding with a write.
    z_i = 2'd0; z_j = 2'd0; z_out = 32'hDEAD_BEEF;
    clear = 1'b1; z_stb = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_ack", 64'(z_ack), 64'(1));
    z_stb = 1'b0;
    @(posedge clk); #1;
    chk("clr_ack_drop", 64'(z_ack), 64'(0));
    chk("clr_wr_count", 64'(wr_count), 64'(1));
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        mdl[i][j] = '0;
    mdl[0][0] = 32'hDEAD_BEEF;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        z_i = 2'(i); z_j = 2'(j);
        #1;
        chk("clr_cell", 64'(current_element), 64'(mdl[i][j]));
      end

    // Reset asserted on the fourth drain beat.
    start_drain();
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_beat", 64'({out_valid, busy, out_i, out_j}), 64'({1'b1, 1'b1, 2'd0, 2'd3}));
    rst = 1'b1;
    #1;
    chk("rst_ctl", 64'({z_ack, out_valid, out_last, busy, out_i, out_j, wr_count}), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        z_i = 2'(i); z_j = 2'(j);
        #1;
        chk("rst_cell", 64'(current_element), 64'(0));
      end
    @(posedge clk); #1;
    do_write(2'd3, 2'd3, 32'h0000_0055);
    chk("post_rst_cur", 64'(current_element), 64'h55);
    chk("post_rst_cnt", 64'(wr_count), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
